// File: rtl/return_coin_dispenser.sv
// Refund coin dispenser: greedy largest-coin selection with per-denomination
// inventory, valid/ack hopper handshake and shortfall reporting.
module return_coin_dispenser #(
  parameter int unsigned NUM_COINS  = 3,
  parameter int unsigned TOTAL_BITS = 31,
  parameter int unsigned COIN_VAL0  = 100,
  parameter int unsigned COIN_VAL1  = 500,
  parameter int unsigned COIN_VAL2  = 1000,
  parameter int unsigned INV_BITS   = 8,
  parameter int unsigned INIT_INV   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_return_req,
  input  logic [TOTAL_BITS-1:0] i_return_amount,
  input  logic                  i_coin_ack,
  input  logic [NUM_COINS-1:0]  i_refill,
  output logic                  o_coin_valid,
  output logic [NUM_COINS-1:0]  o_coin_sel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_shortfall,
  output logic [NUM_COINS-1:0]  o_empty
);

  typedef enum logic [1:0] {StIdle, StSelect, StEmit, StDone} state_e;

  // Denominations above index 2 have no value parameter and are never selected.
  function automatic logic [TOTAL_BITS-1:0] coin_val(input int k);
    case (k)
      0:       coin_val = TOTAL_BITS'(COIN_VAL0);
      1:       coin_val = TOTAL_BITS'(COIN_VAL1);
      2:       coin_val = TOTAL_BITS'(COIN_VAL2);
      default: coin_val = '0;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic [TOTAL_BITS-1:0] remaining_q, remaining_d;
  logic                  valid_q, valid_d;
  logic [NUM_COINS-1:0]  sel_q, sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [TOTAL_BITS-1:0] shortfall_q, shortfall_d;
  logic [NUM_COINS-1:0]  empty_q, empty_d;
  logic [INV_BITS-1:0]   inv_q [NUM_COINS];
  logic [INV_BITS-1:0]   inv_d [NUM_COINS];

  logic                  pick_found;
  logic [NUM_COINS-1:0]  pick_onehot;
  logic [TOTAL_BITS-1:0] sel_val;
  logic [NUM_COINS-1:0]  dispense;

  // Ascending scan so the highest eligible denomination wins.
  always_comb begin
    pick_found  = 1'b0;
    pick_onehot = '0;
    sel_val     = '0;
    for (int k = 0; k < int'(NUM_COINS); k++) begin
      if (coin_val(k) != '0 && coin_val(k) <= remaining_q && inv_q[k] != '0) begin
        pick_found     = 1'b1;
        pick_onehot    = '0;
        pick_onehot[k] = 1'b1;
      end
      if (sel_q[k]) sel_val = sel_val | coin_val(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    valid_d     = valid_q;
    sel_d       = sel_q;
    dispense    = '0;
    unique case (state_q)
      StIdle: begin
        if (i_return_req) begin
          remaining_d = i_return_amount;
          state_d     = (i_return_amount == '0) ? StDone : StSelect;
        end
      end
      StSelect: begin
        if (pick_found) begin
          sel_d   = pick_onehot;
          valid_d = 1'b1;
          state_d = StEmit;
        end else begin
          state_d = StDone;
        end
      end
      StEmit: begin
        if (i_coin_ack) begin
          remaining_d = remaining_q - sel_val;
          dispense    = sel_q;
          valid_d     = 1'b0;
          sel_d       = '0;
          state_d     = (remaining_d == '0) ? StDone : StSelect;
        end
      end
      StDone: begin
        remaining_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    shortfall_d = (state_d == StDone) ? remaining_d : shortfall_q;
  end

  // Refill and dispense of the same denomination on one edge cancel out.
  always_comb begin
    for (int k = 0; k < int'(NUM_COINS); k++) begin
      inv_d[k] = inv_q[k];
      if (dispense[k] && !i_refill[k]) begin
        inv_d[k] = inv_q[k] - INV_BITS'(1);
      end else if (i_refill[k] && !dispense[k] && inv_q[k] != '1) begin
        inv_d[k] = inv_q[k] + INV_BITS'(1);
      end
      empty_d[k] = (inv_d[k] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shortfall_q <= '0;
      empty_q     <= {NUM_COINS{INIT_INV == 0}};
      for (int k = 0; k < int'(NUM_COINS); k++) inv_q[k] <= INV_BITS'(INIT_INV);
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      shortfall_q <= shortfall_d;
      empty_q     <= empty_d;
      for (int k = 0; k < int'(NUM_COINS); k++) inv_q[k] <= inv_d[k];
    end
  end

  assign o_coin_valid = valid_q;
  assign o_coin_sel   = sel_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_shortfall  = shortfall_q;
  assign o_empty      = empty_q;

endmodule
